// File: rtl/ex_stage_pkg.sv
// riscv_pkg: control encodings and the forwarded control bundle shared by the execute stage
package riscv_pkg;
  typedef enum logic [2:0] {CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU} comp_op_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} reg_wr_src_t;
  typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} alu_src1_t;
  typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR} alu_src2_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_MUL
  } alu_op_t;
  typedef enum logic [2:0] {MEM_W, MEM_H, MEM_B, MEM_HU, MEM_BU} mem_ctrl_t;
  typedef struct packed {
    logic        reg_do_write;
    logic        mem_do_write;
    logic        mem_do_read;
    reg_wr_src_t reg_wr_src;
    mem_ctrl_t   mem_ctrl;
    logic [4:0]  rd_addr;
  } ex_ctrl_t;
  localparam ex_ctrl_t NOP_BUNDLE = '0;
endpackage

// File: rtl/ex_stage_if.sv
// ex_in_if / ex_out_if: ID/EX input bundle and EX/MEM output bundle, each with valid/ready
// ex_in_if  master = ID/EX register, slave = ex_stage
// ex_out_if master = ex_stage, slave = MEM stage
interface ex_in_if import riscv_pkg::*; #(parameter int XLEN = 32);
  logic              in_valid, in_ready;
  logic              reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch, do_jump;
  comp_op_t          comp_ctrl;
  reg_wr_src_t       reg_wr_src_ctrl;
  alu_src1_t         alu_op1_ctrl;
  alu_src2_t         alu_op2_ctrl;
  alu_op_t           alu_ctrl;
  mem_ctrl_t         mem_ctrl;
  logic [XLEN-1:0]   pc, rs1_data, rs2_data, imm;
  logic [4:0]        rd_addr;
  modport master (output in_valid, reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch,
                  do_jump, comp_ctrl, reg_wr_src_ctrl, alu_op1_ctrl, alu_op2_ctrl, alu_ctrl, mem_ctrl,
                  pc, rs1_data, rs2_data, imm, rd_addr, input in_ready);
  modport slave  (input in_valid, reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch,
                  do_jump, comp_ctrl, reg_wr_src_ctrl, alu_op1_ctrl, alu_op2_ctrl, alu_ctrl, mem_ctrl,
                  pc, rs1_data, rs2_data, imm, rd_addr, output in_ready);
endinterface

interface ex_out_if import riscv_pkg::*; #(parameter int XLEN = 32);
  logic              out_valid, out_ready;
  logic              out_reg_do_write, out_mem_do_write, out_mem_do_read;
  reg_wr_src_t       out_reg_wr_src;
  mem_ctrl_t         out_mem_ctrl;
  logic [XLEN-1:0]   out_alu_result, out_store_data, out_pc_plus4;
  logic [4:0]        out_rd_addr;
  modport master (output out_valid, out_reg_do_write, out_mem_do_write, out_mem_do_read, out_reg_wr_src,
                  out_mem_ctrl, out_alu_result, out_store_data, out_pc_plus4, out_rd_addr, input out_ready);
  modport slave  (input out_valid, out_reg_do_write, out_mem_do_write, out_mem_do_read, out_reg_wr_src,
                  out_mem_ctrl, out_alu_result, out_store_data, out_pc_plus4, out_rd_addr, output out_ready);
endinterface

// File: rtl/ex_stage_multiplier.sv
// ex_multiplier: iterative shift-add multiplier, low XLEN bits, IDLE -> BUSY (XLEN cycles) -> DONE
// ports: clk, rst (async high), start_i, a_i, b_i -> busy_o (BUSY/DONE), done_o (DONE), product_o
module ex_multiplier #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(XLEN);
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start_i) begin
      state_d = BUSY;
      a_d = a_i;
      b_d = b_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      acc_d = b_q[0] ? acc_q + a_q : acc_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(XLEN - 1) ? DONE : BUSY;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign product_o = acc_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ALU, branch compare/resolve, registered EX/MEM bundle and redirect pulse
// ports: clk, rst (async high), in_if (ex_in_if.slave), out_if (ex_out_if.master),
//        redirect_valid / redirect_pc (one-cycle flush + target)
// EX_MUL_EN: when defined, ALU_MUL uses the iterative ex_multiplier; otherwise it yields 0
module ex_stage import riscv_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  ex_in_if.slave          in_if,
  ex_out_if.master        out_if,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  logic [XLEN-1:0] op1, op2, alu, target, mul_res;
  logic [XLEN-1:0] alu_q, alu_d, store_q, store_d, pc4_q, pc4_d, redir_pc_q, redir_pc_d;
  logic [4:0] sh;
  logic eq, lt, ltu, cmp, take, live, mul_start, mul_busy, mul_done;
  logic out_valid_q, out_valid_d, redir_q, redir_d;
  ex_ctrl_t ctrl_q, ctrl_d;
  assign in_if.in_ready = (!out_valid_q || out_if.out_ready) && !mul_busy;
  // the bundle presented while a redirect is out is wrong-path: accepted, then dropped
  assign live = in_if.in_valid && in_if.in_ready && !redir_q;
  assign op1 = in_if.alu_op1_ctrl == SRC1_PC ? in_if.pc : in_if.alu_op1_ctrl == SRC1_ZERO ? '0 : in_if.rs1_data;
  assign op2 = in_if.alu_op2_ctrl == SRC2_IMM ? in_if.imm : in_if.alu_op2_ctrl == SRC2_FOUR ? XLEN'(4) : in_if.rs2_data;
  assign sh = op2[4:0];
  always_comb begin
    case (in_if.alu_ctrl)
      ALU_ADD:    alu = op1 + op2;
      ALU_SUB:    alu = op1 - op2;
      ALU_SLL:    alu = op1 << sh;
      ALU_SLT:    alu = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU:   alu = {{(XLEN-1){1'b0}}, op1 < op2};
      ALU_XOR:    alu = op1 ^ op2;
      ALU_SRL:    alu = op1 >> sh;
      ALU_SRA:    alu = $unsigned($signed(op1) >>> sh);
      ALU_OR:     alu = op1 | op2;
      ALU_AND:    alu = op1 & op2;
      ALU_PASS_B: alu = op2;
      default:    alu = '0;
    endcase
  end
  assign eq = in_if.rs1_data == in_if.rs2_data;
  assign lt = $signed(in_if.rs1_data) < $signed(in_if.rs2_data);
  assign ltu = in_if.rs1_data < in_if.rs2_data;
  assign cmp = in_if.comp_ctrl == CMP_EQ ? eq : in_if.comp_ctrl == CMP_NE ? !eq :
               in_if.comp_ctrl == CMP_LT ? lt : in_if.comp_ctrl == CMP_GE ? !lt :
               in_if.comp_ctrl == CMP_LTU ? ltu : in_if.comp_ctrl == CMP_GEU ? !ltu : 1'b0;
  assign take = in_if.do_jump || (in_if.do_branch && cmp);
  // JALR is the jump whose operand 1 is rs1; its target drops bit 0
  assign target = in_if.do_jump && in_if.alu_op1_ctrl == SRC1_RS1 ?
                  (in_if.rs1_data + in_if.imm) & {{(XLEN-1){1'b1}}, 1'b0} : in_if.pc + in_if.imm;
`ifdef EX_MUL_EN
  assign mul_start = live && in_if.alu_ctrl == ALU_MUL;
  ex_multiplier #(.XLEN(XLEN)) u_mul (
    .clk(clk), .rst(rst), .start_i(mul_start), .a_i(op1), .b_i(op2),
    .busy_o(mul_busy), .done_o(mul_done), .product_o(mul_res)
  );
`else
  assign mul_start = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res = '0;
`endif
  // a multiply loads its control fields on accept but only raises out_valid when the product lands
  always_comb begin
    ctrl_d = ctrl_q;
    alu_d = alu_q;
    store_d = store_q;
    pc4_d = pc4_q;
    redir_pc_d = live && take ? target : redir_pc_q;
    redir_d = live && take;
    out_valid_d = out_if.out_ready ? 1'b0 : out_valid_q;
    if (live) begin
      ctrl_d = '{reg_do_write: in_if.reg_do_write_ctrl, mem_do_write: in_if.mem_do_write_ctrl,
                 mem_do_read: in_if.mem_do_read_ctrl, reg_wr_src: in_if.reg_wr_src_ctrl,
                 mem_ctrl: in_if.mem_ctrl, rd_addr: in_if.rd_addr};
      alu_d = alu;
      store_d = in_if.rs2_data;
      pc4_d = in_if.pc + XLEN'(4);
      out_valid_d = !mul_start;
    end
    if (mul_done) begin
      alu_d = mul_res;
      out_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= NOP_BUNDLE;
      alu_q <= '0;
      store_q <= '0;
      pc4_q <= '0;
      out_valid_q <= 1'b0;
      redir_q <= 1'b0;
      redir_pc_q <= RESET_PC_VAL;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q <= alu_d;
      store_q <= store_d;
      pc4_q <= pc4_d;
      out_valid_q <= out_valid_d;
      redir_q <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_reg_do_write = ctrl_q.reg_do_write;
  assign out_if.out_mem_do_write = ctrl_q.mem_do_write;
  assign out_if.out_mem_do_read = ctrl_q.mem_do_read;
  assign out_if.out_reg_wr_src = ctrl_q.reg_wr_src;
  assign out_if.out_mem_ctrl = ctrl_q.mem_ctrl;
  assign out_if.out_rd_addr = ctrl_q.rd_addr;
  assign out_if.out_alu_result = alu_q;
  assign out_if.out_store_data = store_q;
  assign out_if.out_pc_plus4 = pc4_q;
  assign redirect_valid = redir_q;
  assign redirect_pc = redir_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table plus hand sequences for squash, stall, reset and multiply
module tb_ex_stage;
  import riscv_pkg::*;
  localparam int XLEN = 32;
  localparam logic [31:0] RPC = 32'hA5A5_0000;
  localparam int NV = 21;
  logic clk = 1'b0;
  logic rst;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  int n_cmp, n_err;
  always #5 clk = ~clk;
  ex_in_if #(.XLEN(XLEN)) in_if ();
  ex_out_if #(.XLEN(XLEN)) out_if ();
  ex_stage #(.XLEN(XLEN), .RESET_PC_VAL(RPC)) dut (
    .clk(clk), .rst(rst), .in_if(in_if), .out_if(out_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  typedef struct {
    alu_op_t op; alu_src1_t s1; alu_src2_t s2; comp_op_t cmp; logic br; logic jmp;
    logic [31:0] pc; logic [31:0] rs1; logic [31:0] rs2; logic [31:0] imm; logic [4:0] rd;
    logic [31:0] exp_alu; logic exp_rv; logic [31:0] exp_rpc;
  } vec_t;
  vec_t vt [NV];
  vec_t mv, av;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic set_in(input vec_t x);
    in_if.alu_ctrl = x.op;
    in_if.alu_op1_ctrl = x.s1;
    in_if.alu_op2_ctrl = x.s2;
    in_if.comp_ctrl = x.cmp;
    in_if.do_branch = x.br;
    in_if.do_jump = x.jmp;
    in_if.pc = x.pc;
    in_if.rs1_data = x.rs1;
    in_if.rs2_data = x.rs2;
    in_if.imm = x.imm;
    in_if.rd_addr = x.rd;
    in_if.reg_do_write_ctrl = 1'b1;
    in_if.mem_do_write_ctrl = x.rd[0];
    in_if.mem_do_read_ctrl = x.rd[1];
    in_if.reg_wr_src_ctrl = x.jmp ? WB_PC4 : WB_ALU;
    in_if.mem_ctrl = x.rd[2] ? MEM_HU : MEM_W;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{ALU_ADD, SRC1_RS1, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h40, 32'd5, 32'h11, 32'hFFFF_FFFD, 5'd1, 32'd2, 1'b0, 32'h0};
    vt[1]  = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_EQ, 1'b0, 1'b0, 32'h44, 32'd10, 32'd3, 32'h0, 5'd2, 32'd7, 1'b0, 32'h0};
    vt[2]  = '{ALU_SLL, SRC1_RS1, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h48, 32'd1, 32'h22, 32'h23, 5'd3, 32'd8, 1'b0, 32'h0};
    vt[3]  = '{ALU_SLT, SRC1_RS1, SRC2_RS2, CMP_EQ, 1'b0, 1'b0, 32'h4C, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd4, 32'd1, 1'b0, 32'h0};
    vt[4]  = '{ALU_SLTU, SRC1_RS1, SRC2_RS2, CMP_EQ, 1'b0, 1'b0, 32'h50, 32'd1, 32'hFFFF_FFFF, 32'h0, 5'd5, 32'd1, 1'b0, 32'h0};
    vt[5]  = '{ALU_XOR, SRC1_RS1, SRC2_RS2, CMP_EQ, 1'b0, 1'b0, 32'h54, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0, 5'd6, 32'h5A5A_A5A5, 1'b0, 32'h0};
    vt[6]  = '{ALU_SRL, SRC1_RS1, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h58, 32'h8000_0000, 32'h33, 32'h4, 5'd7, 32'h0800_0000, 1'b0, 32'h0};
    vt[7]  = '{ALU_SRA, SRC1_RS1, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h5C, 32'h8000_0000, 32'h44, 32'h21, 5'd8, 32'hC000_0000, 1'b0, 32'h0};
    vt[8]  = '{ALU_OR, SRC1_RS1, SRC2_RS2, CMP_NE, 1'b0, 1'b0, 32'h60, 32'hF0, 32'h0F, 32'h0, 5'd9, 32'hFF, 1'b0, 32'h0};
    vt[9]  = '{ALU_AND, SRC1_RS1, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h64, 32'hF0F0, 32'h55, 32'hFF00, 5'd10, 32'hF000, 1'b0, 32'h0};
    vt[10] = '{ALU_PASS_B, SRC1_ZERO, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h68, 32'hDEAD, 32'h66, 32'h1234_5000, 5'd11, 32'h1234_5000, 1'b0, 32'h0};
    vt[11] = '{ALU_ADD, SRC1_PC, SRC2_IMM, CMP_EQ, 1'b0, 1'b0, 32'h200, 32'h77, 32'h12, 32'h1000, 5'd12, 32'h1200, 1'b0, 32'h0};
    vt[12] = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_EQ, 1'b1, 1'b0, 32'h100, 32'd7, 32'd7, 32'h20, 5'd13, 32'h0, 1'b1, 32'h120};
    vt[13] = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_NE, 1'b1, 1'b0, 32'h104, 32'd7, 32'd7, 32'h20, 5'd14, 32'h0, 1'b0, 32'h0};
    vt[14] = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_LT, 1'b1, 1'b0, 32'h300, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFF8, 5'd15, 32'hFFFF_FFFD, 1'b1, 32'h2F8};
    vt[15] = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_GEU, 1'b1, 1'b0, 32'h304, 32'd1, 32'hFFFF_FFFF, 32'h40, 5'd16, 32'd2, 1'b0, 32'h0};
    vt[16] = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_LTU, 1'b1, 1'b0, 32'h400, 32'd1, 32'hFFFF_FFFF, 32'h10, 5'd17, 32'd2, 1'b1, 32'h410};
    vt[17] = '{ALU_SUB, SRC1_RS1, SRC2_RS2, CMP_GE, 1'b1, 1'b0, 32'h500, 32'd5, 32'd5, 32'h4, 5'd18, 32'h0, 1'b1, 32'h504};
    vt[18] = '{ALU_ADD, SRC1_PC, SRC2_FOUR, CMP_EQ, 1'b0, 1'b1, 32'h600, 32'h88, 32'h99, 32'h100, 5'd19, 32'h604, 1'b1, 32'h700};
    vt[19] = '{ALU_ADD, SRC1_RS1, SRC2_IMM, CMP_EQ, 1'b0, 1'b1, 32'h800, 32'h1003, 32'hAA, 32'h4, 5'd20, 32'h1007, 1'b1, 32'h1006};
    vt[20] = '{ALU_ADD, SRC1_PC, SRC2_FOUR, CMP_EQ, 1'b0, 1'b1, 32'h900, 32'h1, 32'hBB, 32'h2, 5'd21, 32'h904, 1'b1, 32'h902};
    mv = '{ALU_MUL, SRC1_RS1, SRC2_RS2, CMP_EQ, 1'b0, 1'b0, 32'hA00, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 5'd22, 32'hFFFF_FFFF, 1'b0, 32'h0};
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_if.in_valid = 1'b0;
    out_if.out_ready = 1'b1;
    set_in(vt[0]);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_if.out_valid), 32'd0);
    chk("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst.redirect_pc", redirect_pc, RPC);
    chk("rst.alu", out_if.out_alu_result, 32'd0);
    chk("rst.rd", 32'(out_if.out_rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_if.in_ready), 32'd1);
    for (int i = 0; i < NV; i++) begin
      set_in(vt[i]);
      in_if.in_valid = 1'b1;
      @(negedge clk);
      in_if.in_valid = 1'b0;
      chk($sformatf("v%0d.valid", i), 32'(out_if.out_valid), 32'd1);
      chk($sformatf("v%0d.alu", i), out_if.out_alu_result, vt[i].exp_alu);
      chk($sformatf("v%0d.pc4", i), out_if.out_pc_plus4, vt[i].pc + 32'd4);
      chk($sformatf("v%0d.store", i), out_if.out_store_data, vt[i].rs2);
      chk($sformatf("v%0d.rd", i), 32'(out_if.out_rd_addr), 32'(vt[i].rd));
      chk($sformatf("v%0d.ctrl", i),
          32'({out_if.out_reg_do_write, out_if.out_mem_do_write, out_if.out_mem_do_read, out_if.out_reg_wr_src, out_if.out_mem_ctrl}),
          32'({1'b1, vt[i].rd[0], vt[i].rd[1], vt[i].jmp ? WB_PC4 : WB_ALU, vt[i].rd[2] ? MEM_HU : MEM_W}));
      chk($sformatf("v%0d.redir", i), 32'(redirect_valid), 32'(vt[i].exp_rv));
      if (vt[i].exp_rv) chk($sformatf("v%0d.redir_pc", i), redirect_pc, vt[i].exp_rpc);
      @(negedge clk);
      chk($sformatf("v%0d.drain", i), 32'(out_if.out_valid), 32'd0);
      chk($sformatf("v%0d.pulse", i), 32'(redirect_valid), 32'd0);
    end
    // squash: bundle presented during the redirect cycle is accepted and dropped
    set_in(vt[12]);
    in_if.in_valid = 1'b1;
    @(negedge clk);
    chk("sq.redir", 32'(redirect_valid), 32'd1);
    chk("sq.redir_pc", redirect_pc, 32'h120);
    av = vt[0];
    av.rd = 5'd3;
    set_in(av);
    chk("sq.in_ready", 32'(in_if.in_ready), 32'd1);
    @(negedge clk);
    chk("sq.dropped", 32'(out_if.out_valid), 32'd0);
    chk("sq.no_redir", 32'(redirect_valid), 32'd0);
    av.rd = 5'd4;
    set_in(av);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("sq.after.valid", 32'(out_if.out_valid), 32'd1);
    chk("sq.after.rd", 32'(out_if.out_rd_addr), 32'd4);
    @(negedge clk);
    // stall: JAL accepted with out_ready low, then held for three cycles
    out_if.out_ready = 1'b0;
    set_in(vt[18]);
    in_if.in_valid = 1'b1;
    @(negedge clk);
    chk("st.valid", 32'(out_if.out_valid), 32'd1);
    chk("st.redir", 32'(redirect_valid), 32'd1);
    chk("st.redir_pc", redirect_pc, 32'h700);
    chk("st.in_ready", 32'(in_if.in_ready), 32'd0);
    av.rd = 5'd7;
    set_in(av);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("st%0d.alu", k), out_if.out_alu_result, 32'h604);
      chk($sformatf("st%0d.rd", k), 32'(out_if.out_rd_addr), 32'd19);
      chk($sformatf("st%0d.valid", k), 32'(out_if.out_valid), 32'd1);
      chk($sformatf("st%0d.in_ready", k), 32'(in_if.in_ready), 32'd0);
      chk($sformatf("st%0d.redir", k), 32'(redirect_valid), 32'd0);
    end
    out_if.out_ready = 1'b1;
    #1;
    chk("st.release.in_ready", 32'(in_if.in_ready), 32'd1);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("st.swap.valid", 32'(out_if.out_valid), 32'd1);
    chk("st.swap.alu", out_if.out_alu_result, 32'd2);
    chk("st.swap.rd", 32'(out_if.out_rd_addr), 32'd7);
    @(negedge clk);
    chk("st.drain", 32'(out_if.out_valid), 32'd0);
    // reset during a stall
    out_if.out_ready = 1'b0;
    set_in(vt[1]);
    in_if.in_valid = 1'b1;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("rs.valid", 32'(out_if.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs.out_valid", 32'(out_if.out_valid), 32'd0);
    chk("rs.alu", out_if.out_alu_result, 32'd0);
    chk("rs.rd", 32'(out_if.out_rd_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_if.out_ready = 1'b1;
    @(negedge clk);
    chk("rs.in_ready", 32'(in_if.in_ready), 32'd1);
`ifdef EX_MUL_EN
    set_in(mv);
    in_if.in_valid = 1'b1;
    @(negedge clk);
    set_in(vt[0]);
    for (int k = 1; k <= XLEN + 1; k++) begin
      chk($sformatf("mul%0d.in_ready", k), 32'(in_if.in_ready), 32'd0);
      chk($sformatf("mul%0d.valid", k), 32'(out_if.out_valid), 32'd0);
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
    chk("mul.valid", 32'(out_if.out_valid), 32'd1);
    chk("mul.alu", out_if.out_alu_result, 32'hFFFF_FFFF);
    chk("mul.rd", 32'(out_if.out_rd_addr), 32'd22);
    @(negedge clk);
    chk("mul.drain", 32'(out_if.out_valid), 32'd0);
    set_in(mv);
    in_if.in_valid = 1'b1;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrs.busy", 32'(in_if.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mrs.out_valid", 32'(out_if.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrs.in_ready", 32'(in_if.in_ready), 32'd1);
    repeat (XLEN + 4) @(negedge clk);
    chk("mrs.aborted", 32'(out_if.out_valid), 32'd0);
`else
    set_in(mv);
    in_if.in_valid = 1'b1;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("mul.valid", 32'(out_if.out_valid), 32'd1);
    chk("mul.alu", out_if.out_alu_result, 32'd0);
    chk("mul.rd", 32'(out_if.out_rd_addr), 32'd22);
    @(negedge clk);
    chk("mul.drain", 32'(out_if.out_valid), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that sits downstream of the ID/EX pipeline register and consumes its control bundle plus operands.
- Performs ALU, comparison and branch/jump resolution.
- Registers results into an EX/MEM-facing output bundle with a valid/ready handshake.
- Issues a one-cycle registered redirect (flush + target PC) to fetch/decode on taken branches and jumps.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_VAL, 32'h0000_0000, value driven on redirect_pc during reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- reg_do_write_ctrl  in  1  RegWrite
- mem_do_write_ctrl  in  1  MemWrite
- mem_do_read_ctrl  in  1  MemRead
- do_branch  in  1  conditional branch
- do_jump  in  1  JAL/JALR
- comp_ctrl  in  comp_op_t  branch compare op
- reg_wr_src_ctrl  in  reg_wr_src_t  writeback source select
- alu_op1_ctrl  in  alu_src1_t  operand-1 select
- alu_op2_ctrl  in  alu_src2_t  operand-2 select
- alu_ctrl  in  alu_op_t  ALU operation
- mem_ctrl  in  mem_ctrl_t  load/store size/sign
- pc  in  XLEN  instruction PC
- rs1_data  in  XLEN  source register 1 value
- rs2_data  in  XLEN  source register 2 value
- imm  in  XLEN  sign-extended immediate
- rd_addr  in  5  destination register
- out_valid  out  1  output bundle valid
- out_ready  in  1  MEM stage accepts
- out_reg_do_write, out_mem_do_write, out_mem_do_read  out  1 each  forwarded controls
- out_reg_wr_src  out  reg_wr_src_t  forwarded writeback source
- out_mem_ctrl  out  mem_ctrl_t  forwarded memory control
- out_alu_result  out  XLEN  ALU result / memory address
- out_store_data  out  XLEN  rs2_data copy
- out_pc_plus4  out  XLEN  pc+4, link value
- out_rd_addr  out  5  destination register
- redirect_valid  out  1  one-cycle flush/redirect pulse
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, redirect_valid=0, squash=0.
  - All out_* data and control fields = 0; redirect_pc=RESET_PC_VAL.
  - Any in-flight multiply is aborted.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !mul_busy.
  - Latency is 1 cycle: accepted bundle appears on out_* at the next edge with out_valid=1.
  - out_* hold stable while out_valid && !out_ready.
  - out_valid drops when the output is consumed and nothing new is accepted.
- Operand selection:
  - op1: SRC1_RS1 -> rs1_data; SRC1_PC -> pc; SRC1_ZERO -> 0.
  - op2: SRC2_RS2 -> rs2_data; SRC2_IMM -> imm; SRC2_FOUR -> 4.
- ALU:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B, MUL.
  - Shift amount is op2[4:0]; all arithmetic is mod 2^XLEN.
- Compare on rs1_data vs rs2_data:
  - CMP_EQ, CMP_NE, CMP_LT (signed), CMP_GE (signed), CMP_LTU, CMP_GEU.
- Branch/jump resolution:
  - take = do_jump || (do_branch && cmp_true).
  - Target: JALR (do_jump && alu_op1_ctrl==SRC1_RS1) -> (rs1_data+imm) & ~1; otherwise pc+imm.
  - On acceptance with take=1: next edge sets redirect_valid=1 and redirect_pc=target for exactly one cycle, even if the output is stalled. The instruction itself still flows to out_*.
  - Misaligned targets are passed through unchanged; no trap.
- Squash:
  - The cycle redirect_valid=1, any in_valid bundle is wrong-path.
  - The block accepts it (in_ready as normal) and discards it: no out_valid, no redirect.
  - squash clears after that one cycle whether or not a bundle was presented.
- Simultaneous events:
  - Output consumed and new bundle accepted on the same edge -> out_valid stays 1 with new data.
  - Reset mid-stall or mid-multiply returns to the reset state.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined:
  - ALU_MUL runs an iterative shift-add multiplier (low XLEN bits of the product).
  - FSM: IDLE -> BUSY (XLEN cycles) -> DONE (loads output register, returns to IDLE).
  - mul_busy=1 in BUSY/DONE, so in_ready=0.
  - Accept-to-out_valid latency is XLEN+2 cycles.
- Undefined:
  - ALU_MUL yields out_alu_result=0.
  - Latency is 1 cycle; mul_busy is tied 0.

Decomposition:
- Package riscv_pkg holds:
  - enums comp_op_t, reg_wr_src_t, alu_src1_t, alu_src2_t, alu_op_t, mem_ctrl_t.
  - localparam NOP_BUNDLE (all-zero control).
- One sub-module: ex_multiplier (the iterative FSM), instantiated only under EX_MUL_EN.
- ALU and comparator stay inline combinational logic.

Test Plan:
- ADD with rs1=5, imm=-3, SRC2_IMM, out_ready=1 -> next cycle out_valid=1, out_alu_result=2, out_rd_addr echoed; redirect_valid=0.
- BEQ, rs1=rs2=7, pc=0x100, imm=0x20 -> redirect_valid=1 for exactly one cycle, redirect_pc=0x120; a bundle presented that cycle is dropped (no out_valid).
- JALR, rs1=0x1003, imm=4 -> redirect_pc=0x1006; out_pc_plus4=pc+4.
- out_ready=0 for 3 cycles after an accept -> out_* stable, in_ready=0, redirect pulses once only.
- SRA, rs1=0x8000_0000, op2=0x21 -> out_alu_result=0xC000_0000 (shift of 1). Also SLTU with rs1=1, rs2=0xFFFF_FFFF -> 1.
- EX_MUL_EN: MUL 0xFFFF x 0x10001 -> result 0xFFFFFFFF after XLEN+2 cycles, in_ready=0 throughout; assert rst mid-BUSY -> out_valid=0, in_ready=1 after release.
